// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory request, 1-entry skid buffer, branch squash.
// Define IF_PERF_CNT_EN to add delivered-instruction and stall-cycle counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o,
`endif
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e      state;
  logic [31:0] fetch_pc;
  logic [31:0] redirect_pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic        kill;

  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] next_pc;

  assign branch_taken = branch_flag_i & ~stall_i;
  assign branch_pc    = {branch_target_address_i[31:2], 2'b00};
  assign next_pc      = fetch_pc + 32'd4;
  assign mem_addr_o   = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      fetch_pc     <= RESET_PC;
      redirect_pc  <= RESET_PC;
      mem_req_o    <= 1'b0;
      pc_o         <= 32'h0;
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
      skid_pc      <= 32'h0;
      skid_inst    <= NOP_INST;
      kill         <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          state     <= StFetch;
          mem_req_o <= 1'b1;
        end

        StFetch: begin
          if (branch_taken) begin
            inst_valid_o <= 1'b0;
            inst_o       <= NOP_INST;
            if (mem_ack_i) begin
              fetch_pc <= branch_pc;
              kill     <= 1'b0;
            end else begin
              // Outstanding request must finish at its original address; drop it on ack.
              redirect_pc <= branch_pc;
              kill        <= 1'b1;
            end
          end else if (mem_ack_i) begin
            if (kill) begin
              fetch_pc <= redirect_pc;
              kill     <= 1'b0;
              if (!stall_i) begin
                inst_valid_o <= 1'b0;
                inst_o       <= NOP_INST;
              end
            end else if (stall_i) begin
              skid_pc   <= fetch_pc;
              skid_inst <= mem_rdata_i;
              fetch_pc  <= next_pc;
              mem_req_o <= 1'b0;
              state     <= StHold;
            end else begin
              pc_o         <= fetch_pc;
              inst_o       <= mem_rdata_i;
              inst_valid_o <= 1'b1;
              fetch_pc     <= next_pc;
            end
          end else if (!stall_i) begin
            inst_valid_o <= 1'b0;
            inst_o       <= NOP_INST;
          end
        end

        StHold: begin
          if (!stall_i) begin
            state     <= StFetch;
            mem_req_o <= 1'b1;
            skid_inst <= NOP_INST;
            if (branch_taken) begin
              fetch_pc     <= branch_pc;
              inst_valid_o <= 1'b0;
              inst_o       <= NOP_INST;
            end else begin
              pc_o         <= skid_pc;
              inst_o       <= skid_inst;
              inst_valid_o <= 1'b1;
            end
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic deliver;

  assign deliver = ~stall_i & ~branch_flag_i &
                   (((state == StFetch) & mem_ack_i & ~kill) | (state == StHold));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt_o <= 32'h0;
      perf_stall_cnt_o <= 32'h0;
    end else begin
      if (deliver) perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      if (stall_i) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed stimulus, delivered instructions checked by a scoreboard monitor.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] KEY = 32'h13579BDF;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Instruction memory: each word is its address scrambled with a key.
  assign mem_rdata = mem_addr ^ KEY;

  if_stage dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_i                 (stall),
    .branch_flag_i           (branch_flag),
    .branch_target_address_i (branch_target),
    .mem_req_o               (mem_req),
    .mem_addr_o              (mem_addr),
    .mem_ack_i               (mem_ack),
    .mem_rdata_i             (mem_rdata),
    .pc_o                    (pc),
    .inst_o                  (inst),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt_o        (perf_fetch_cnt),
    .perf_stall_cnt_o        (perf_stall_cnt),
`endif
    .inst_valid_o            (inst_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"}, {31'h0, mem_req}, 32'h0);
    check({tag, "_addr"}, mem_addr, 32'h0);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_inst"}, inst, NOP);
    check({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
  endtask

  // Monitor: a new instruction is presented when valid is high after an unstalled edge.
  initial begin
    logic        st;
    logic        rs;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      st = stall;
      rs = rst;
      #1;
      if (!rs && !st && inst_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: delivered pc %h, none expected", pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", pc, e);
          check("sb_inst", inst, e ^ KEY);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'h0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");

    // Zero-wait streaming from RESET_PC.
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    rst = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    check("first_req", {31'h0, mem_req}, 32'h1);
    check("first_addr", mem_addr, 32'h0);
    check("first_valid", {31'h0, inst_valid}, 32'h0);
    @(negedge clk);
    check("stream_addr4", mem_addr, 32'h4);
    check("stream_pc0", pc, 32'h0);
    check("stream_valid", {31'h0, inst_valid}, 32'h1);
    @(negedge clk);
    check("stream_addr8", mem_addr, 32'h8);
    check("stream_pc4", pc, 32'h4);
    @(negedge clk);
    @(negedge clk);
    check("pre_stall_addr", mem_addr, 32'h10);

    // Stall three cycles while 0x10 is acked: skid buffer holds it.
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_req", {31'h0, mem_req}, 32'h0);
      check("hold_pc", pc, 32'hC);
      check("hold_inst", inst, 32'hC ^ KEY);
      check("hold_valid", {31'h0, inst_valid}, 32'h1);
    end
    stall = 1'b0;
    exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    @(negedge clk);
    check("release_pc", pc, 32'h10);
    check("release_addr", mem_addr, 32'h14);
    check("release_req", {31'h0, mem_req}, 32'h1);
    @(negedge clk);

    // Branch with simultaneous ack; misaligned target.
    branch_flag = 1'b1; branch_target = 32'h103;
    @(negedge clk);
    branch_flag = 1'b0;
    check("br_valid", {31'h0, inst_valid}, 32'h0);
    check("br_inst", inst, NOP);
    check("br_addr", mem_addr, 32'h100);
    exp_q.push_back(32'h100);
    @(negedge clk);
    check("br_pc", pc, 32'h100);

    // Slow memory: branch while request pending, killed data must not appear.
    mem_ack = 1'b0;
    @(negedge clk);
    check("noack_valid", {31'h0, inst_valid}, 32'h0);
    check("noack_inst", inst, NOP);
    check("pend_addr1", mem_addr, 32'h104);
    branch_flag = 1'b1; branch_target = 32'h200;
    @(negedge clk);
    branch_flag = 1'b0;
    check("pend_addr2", mem_addr, 32'h104);
    check("pend_req", {31'h0, mem_req}, 32'h1);
    @(negedge clk);
    check("pend_addr3", mem_addr, 32'h104);
    mem_ack = 1'b1;
    @(negedge clk);
    check("kill_addr", mem_addr, 32'h200);
    check("kill_valid", {31'h0, inst_valid}, 32'h0);
    exp_q.push_back(32'h200);
    @(negedge clk);
    check("kill_pc", pc, 32'h200);

    // Address wrap at top of memory.
    branch_flag = 1'b1; branch_target = 32'hFFFFFFFC;
    @(negedge clk);
    branch_flag = 1'b0;
    check("wrap_addr_top", mem_addr, 32'hFFFFFFFC);
    exp_q.push_back(32'hFFFFFFFC); exp_q.push_back(32'h0);
    @(negedge clk);
    check("wrap_addr0", mem_addr, 32'h0);
    check("wrap_pc_top", pc, 32'hFFFFFFFC);
    @(negedge clk);
    check("wrap_pc0", pc, 32'h0);

    // Branch during stall is ignored.
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h300;
    @(negedge clk);
    check("stall_br_req", {31'h0, mem_req}, 32'h0);
    check("stall_br_pc", pc, 32'h0);
    stall = 1'b0; branch_flag = 1'b0;
    exp_q.push_back(32'h4);
    @(negedge clk);
    check("stall_br_pc4", pc, 32'h4);
    check("stall_br_addr", mem_addr, 32'h8);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, 32'd11);
    check("perf_stall", perf_stall_cnt, 32'd4);
`endif

    // Reset mid-request, then a late ack while idle.
    mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    check_reset_state("mid_reset");
`ifdef IF_PERF_CNT_EN
    check("perf_fetch_rst", perf_fetch_cnt, 32'd0);
    check("perf_stall_rst", perf_stall_cnt, 32'd0);
`endif
    rst = 1'b0;
    exp_q.push_back(32'h0);
    @(negedge clk);
    check("late_ack_valid", {31'h0, inst_valid}, 32'h0);
    check("late_ack_addr", mem_addr, 32'h0);
    check("late_ack_req", {31'h0, mem_req}, 32'h1);
    @(negedge clk);
    check("restart_pc", pc, 32'h0);
    check("restart_valid", {31'h0, inst_valid}, 32'h1);
    mem_ack = 1'b0;
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
